// File: rtl/sad_buf_fill_sched.sv
// Shared fill scheduler: round-robin grants the single data-memory read port to
// one core at a time and streams a full row into that core's SAD line buffer.
module sad_buf_fill_sched #(
  parameter int NCORES    = 4,
  parameter int ROW_WORDS = 16,
  parameter int IDX_W     = 4,
  parameter int CORE_W    = 2
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [NCORES-1:0]      req,
  input  logic [32*NCORES-1:0]   req_addr,
  input  logic [NCORES-1:0]      flush,
  output logic                   mem_rd_en,
  output logic [31:0]            mem_addr,
  input  logic [31:0]            mem_rd_data,
  input  logic                   mem_rd_valid,
  output logic [NCORES-1:0]      buf_wr_en,
  output logic [IDX_W-1:0]       buf_wr_idx,
  output logic [31:0]            buf_wr_data,
  output logic [NCORES-1:0]      buf_full,
  output logic [CORE_W-1:0]      owner,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARB   = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [IDX_W:0]   ROW_CNT  = (IDX_W+1)'(ROW_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_WORDS - 1);

  logic [1:0]        r_state;
  logic [CORE_W-1:0] r_owner;
  logic [CORE_W-1:0] r_rr_ptr;
  logic [31:0]       r_base;
  logic [IDX_W-1:0]  r_issue_cnt;
  logic [IDX_W:0]    r_acc_cnt;
  logic [IDX_W-1:0]  r_ret_cnt;
  logic              r_pend;
  logic [31:0]       r_data;
  logic [NCORES-1:0] r_buf_full;

  logic [NCORES-1:0] w_elig;
  logic              w_found;
  logic [CORE_W-1:0] w_pick;
  logic [CORE_W-1:0] w_idx;
  logic              w_active;
  logic              w_accept;
  logic              w_done;

  // First eligible core at or after the round-robin pointer, wrapping.
  always_comb begin
    w_elig  = req & ~r_buf_full;
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NCORES; k++) begin
      w_idx = r_rr_ptr + CORE_W'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_active = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_accept = w_active && mem_rd_valid && (r_acc_cnt < ROW_CNT);
  assign w_done   = (r_state == S_DRAIN) && r_pend && (r_ret_cnt == LAST_IDX);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_acc_cnt   <= '0;
      r_ret_cnt   <= '0;
      r_pend      <= 1'b0;
      r_data      <= '0;
      r_buf_full  <= '0;
    end else begin
      r_pend <= w_accept;
      if (w_accept) begin
        r_data    <= mem_rd_data;
        r_acc_cnt <= r_acc_cnt + 1'b1;
      end
      if (r_pend) r_ret_cnt <= r_ret_cnt + 1'b1;

      case (r_state)
        S_IDLE: if (|w_elig) r_state <= S_ARB;
        S_ARB: begin
          if (w_found) begin
            r_owner     <= w_pick;
            r_base      <= req_addr[32*w_pick +: 32];
            r_issue_cnt <= '0;
            r_acc_cnt   <= '0;
            r_ret_cnt   <= '0;
            r_state     <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_issue_cnt <= r_issue_cnt + 1'b1;
          if (r_issue_cnt == LAST_IDX) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_done) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= r_owner + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Completion set takes priority; the owner's flag is protected for the whole fill.
      for (int unsigned i = 0; i < NCORES; i++) begin
        if (w_done && (r_owner == CORE_W'(i)))
          r_buf_full[i] <= 1'b1;
        else if (flush[i] && !(w_active && (r_owner == CORE_W'(i))))
          r_buf_full[i] <= 1'b0;
      end
    end
  end

  assign mem_rd_en   = (r_state == S_ISSUE);
  assign mem_addr    = (r_state == S_ISSUE) ?
                       r_base + {{(30-IDX_W){1'b0}}, r_issue_cnt, 2'b00} : '0;
  assign buf_wr_en   = r_pend ? (NCORES'(1) << r_owner) : '0;
  assign buf_wr_idx  = r_ret_cnt;
  assign buf_wr_data = r_data;
  assign buf_full    = r_buf_full;
  assign owner       = r_owner;
  assign busy        = w_active;

endmodule

// File: tb/tb_sad_buf_fill_sched.sv
// Bench for sad_buf_fill_sched: fixed-latency memory model, round-robin grant
// model and per-fill address/write/timing checks.
module tb_sad_buf_fill_sched;
  localparam int NC = 4;
  localparam int RW = 16;
  localparam int IW = 4;
  localparam int CW = 2;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic [NC-1:0]    req;
  logic [32*NC-1:0] req_addr;
  logic [NC-1:0]    flush;
  logic             mem_rd_en;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_rd_data;
  logic             mem_rd_valid;
  logic [NC-1:0]    buf_wr_en;
  logic [IW-1:0]    buf_wr_idx;
  logic [31:0]      buf_wr_data;
  logic [NC-1:0]    buf_full;
  logic [CW-1:0]    owner;
  logic             busy;

  sad_buf_fill_sched #(.NCORES(NC), .ROW_WORDS(RW), .IDX_W(IW), .CORE_W(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .req(req), .req_addr(req_addr), .flush(flush),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .buf_wr_en(buf_wr_en), .buf_wr_idx(buf_wr_idx),
    .buf_wr_data(buf_wr_data), .buf_full(buf_full), .owner(owner), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Memory model: word returned lat cycles after its read strobe.
  int          lat   = 1;
  logic        stale = 1'b0;
  logic [31:0] salt;
  logic        pv [0:7];
  logic [31:0] pa [0:7];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  assign mem_rd_valid = pv[lat] | stale;
  assign mem_rd_data  = memfn(pa[lat]);

  logic [31:0]   addr_log [$];
  logic [NC-1:0] en_log   [$];
  logic [IW-1:0] idx_log  [$];
  logic [31:0]   dat_log  [$];

  always @(negedge Clk) begin
    if (mem_rd_en) addr_log.push_back(mem_addr);
    if (buf_wr_en != '0) begin
      en_log.push_back(buf_wr_en);
      idx_log.push_back(buf_wr_idx);
      dat_log.push_back(buf_wr_data);
    end
    for (int k = 7; k > 0; k--) begin
      pv[k] = pv[k-1];
      pa[k] = pa[k-1];
    end
    pv[0] = mem_rd_en;
    pa[0] = mem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_winner(input logic [NC-1:0] r, input logic [NC-1:0] f,
                                    input int ptr);
    for (int k = 0; k < NC; k++) begin
      int i;
      i = (ptr + k) % NC;
      if (r[i] && !f[i]) return i;
    end
    return -1;
  endfunction

  logic [31:0]   bases [NC];
  logic [NC-1:0] m_full;
  int            m_ptr;

  task automatic set_base(input int c, input logic [31:0] b);
    bases[c] = b;
    req_addr[32*c +: 32] = b;
  endtask

  task automatic pulse_flush(input logic [NC-1:0] m);
    flush = m;
    @(negedge Clk);
    flush = '0;
  endtask

  // Waits for grant, checks the complete fill of one core; returns the first ISSUE cycle.
  task automatic run_fill(input int core, input logic [31:0] base, input bit race,
                          output int t0);
    bit got;
    int n;
    addr_log.delete(); en_log.delete(); idx_log.delete(); dat_log.delete();
    got = 0;
    t0  = cyc;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge Clk);
      if (busy) got = 1;
    end
    chk("busy_rise", 32'(got), 1);
    if (!got) return;
    t0 = cyc;
    chk("owner", 32'(owner), 32'(core));
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      n = cyc - t0;
      if (race) flush = (n == 5 || n == RW + lat) ? NC'(1) << core : '0;
      @(negedge Clk);
      if (buf_full[core]) got = 1;
    end
    flush = '0;
    chk("full_set", 32'(got), 1);
    chk("fill_latency", 32'(cyc - t0), 32'(RW + lat + 1));
    chk("busy_done", 32'(busy), 0);
    chk("n_issue", 32'(addr_log.size()), RW);
    chk("n_write", 32'(en_log.size()), RW);
    for (int k = 0; k < RW && k < addr_log.size(); k++)
      chk("issue_addr", addr_log[k], base + 32'(4 * k));
    for (int k = 0; k < RW && k < en_log.size(); k++) begin
      chk("wr_en", 32'(en_log[k]), 32'(NC'(1) << core));
      chk("wr_idx", 32'(idx_log[k]), 32'(k));
      chk("wr_data", dat_log[k], memfn(base + 32'(4 * k)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tf, w;
    logic [NC-1:0] fm, rm;
    for (int k = 0; k < 8; k++) begin pv[k] = 1'b0; pa[k] = '0; end
    salt = $urandom;
    Rst_n = 1'b0; req = '0; flush = '0; req_addr = '0;
    m_full = '0; m_ptr = 0;
    for (int c = 0; c < NC; c++) set_base(c, $urandom & 32'hFFFF_FFFC);
    repeat (3) @(negedge Clk);
    chk("rst_ctl", {30'd0, mem_rd_en, busy}, 0);
    chk("rst_vec", 32'({buf_wr_en, buf_wr_idx, buf_full, owner}), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", buf_wr_data, 0);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Single request, latency 1
    set_base(0, 32'h0000_0100);
    req = 4'b0001;
    run_fill(0, 32'h100, 0, t0);
    req = '0;
    m_full[0] = 1'b1; m_ptr = 1;
    pulse_flush(4'b0001);
    m_full[0] = 1'b0;
    chk("flush_clear", 32'(buf_full), 0);

    // Round robin with all requests held
    req = 4'b1111;
    for (int it = 0; it < 5; it++) begin
      w = exp_winner(req, m_full, m_ptr);
      run_fill(w, bases[w], 0, t0);
      m_ptr = (w + 1) % NC;
      if (it == 4) req = '0;
      pulse_flush(NC'(1) << w);
    end
    repeat (4) @(negedge Clk);

    // Randomized masks, latencies and partial flushes
    for (int it = 0; it < 6; it++) begin
      repeat (8) @(negedge Clk);
      lat = $urandom_range(1, 4);
      for (int c = 0; c < NC; c++) set_base(c, $urandom & 32'hFFFF_FFFC);
      fm = NC'($urandom) & m_full;
      if ((m_full & ~fm) == '1) fm[$urandom_range(0, NC-1)] = 1'b1;
      if (fm != '0) pulse_flush(fm);
      m_full = m_full & ~fm;
      chk("rand_full_pre", 32'(buf_full), 32'(m_full));
      rm = NC'($urandom_range(1, 15));
      if ((rm & ~m_full) == '0) rm = rm | ~m_full;
      req = rm;
      w = exp_winner(rm, m_full, m_ptr);
      run_fill(w, bases[w], 0, t0);
      req = '0;
      m_full[w] = 1'b1; m_ptr = (w + 1) % NC;
      @(negedge Clk);
      chk("rand_full_post", 32'(buf_full), 32'(m_full));
    end

    // Full flag blocks a held request until flushed
    repeat (6) @(negedge Clk);
    lat = 1;
    if (m_full != '0) pulse_flush(m_full);
    m_full = '0;
    req = 4'b0100;
    run_fill(2, bases[2], 0, t0);
    m_ptr = 3;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk("blocked_idle", {30'd0, mem_rd_en, busy}, 0);
    end
    tf = cyc;
    pulse_flush(4'b0100);
    run_fill(2, bases[2], 0, t0);
    chk("flush_to_issue", 32'(t0 - tf), 3);
    req = '0;
    pulse_flush(4'b0100);

    // Owner flush during fill and on the completion cycle
    repeat (4) @(negedge Clk);
    rm = NC'($urandom_range(1, 15));
    req = rm;
    w = exp_winner(rm, '0, m_ptr);
    run_fill(w, bases[w], 1, t0);
    req = '0;
    m_ptr = (w + 1) % NC;
    repeat (2) @(negedge Clk);
    chk("race_full_kept", 32'(buf_full[w]), 1);

    // Asynchronous reset with 7 words issued
    repeat (4) @(negedge Clk);
    addr_log.delete();
    req = 4'b0010;
    for (int i = 0; i < 60 && addr_log.size() < 7; i++) @(negedge Clk);
    chk("pre_rst_issues", 32'(addr_log.size()), 7);
    @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_ctl", {30'd0, mem_rd_en, busy}, 0);
    chk("arst_vec", 32'({buf_wr_en, buf_wr_idx, buf_full, owner}), 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_data", buf_wr_data, 0);
    req = '0; m_full = '0; m_ptr = 0;
    repeat (2) @(negedge Clk);
    en_log.delete();
    Rst_n = 1'b1;
    stale = 1'b1;
    repeat (2) @(negedge Clk);
    stale = 1'b0;
    repeat (3) @(negedge Clk);
    chk("stale_ignored", 32'(en_log.size()), 0);
    set_base(1, $urandom & 32'hFFFF_FFFC);
    req = 4'b0010;
    run_fill(1, bases[1], 0, t0);
    req = '0;
    m_full[1] = 1'b1; m_ptr = 2;

    // Latency 3 with address wrap past 0xFFFFFFFC
    repeat (6) @(negedge Clk);
    lat = 3;
    set_base(0, 32'hFFFF_FFF0);
    req = 4'b0001;
    run_fill(0, 32'hFFFF_FFF0, 0, t0);
    req = '0;
    @(negedge Clk);
    chk("wrap_full", 32'(buf_full), 32'(4'b0011));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sad_buf_fill_sched.md
Name: sad_buf_fill_sched

Overview:
- Shared scheduler that fills the per-core SAD line buffers from the single shared data-memory read port.
- Each core raises a fill request when its decode stage stalls on a buffer-load op (stall term: need_buff & ~all_buf_flags).
- Grants round-robin, streams ROW_WORDS consecutive words into the winner's buffer, then raises that core's buf_full flag.
- buf_full feeds each core's all_buf_flags input.

Parameters:
NCORES, 4, number of requesting cores (power of 2, 2..8)
ROW_WORDS, 16, words per buffer row fill (power of 2, 2..64)
IDX_W, 4, log2(ROW_WORDS)
CORE_W, 2, log2(NCORES)

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
req  in  NCORES  per-core fill request, level; held until buf_full of that core is seen
req_addr  in  32*NCORES  per-core row base byte address; core i at bits [32i+31:32i]; word-aligned
flush  in  NCORES  one-cycle pulse; core consumed its buffer, clears buf_full
mem_rd_en  out  1  read strobe to shared memory port
mem_addr  out  32  read byte address
mem_rd_data  in  32  returned word
mem_rd_valid  in  1  returned word valid; in-order, fixed latency >=1
buf_wr_en  out  NCORES  one-hot write strobe into owner's buffer
buf_wr_idx  out  IDX_W  word index within row
buf_wr_data  out  32  mem_rd_data registered
buf_full  out  NCORES  per-core row-ready flag (to all_buf_flags)
owner  out  CORE_W  currently granted core; valid when busy=1
busy  out  1  fill in progress

Behaviour:
- Reset (Rst_n=0, async): state=IDLE, rr_ptr=0, owner=0, all counters 0, mem_rd_en=0, mem_addr=0, buf_wr_en=0, buf_wr_idx=0, buf_wr_data=0, buf_full=0, busy=0. Reset mid-fill abandons the fill; a late mem_rd_valid after reset release while IDLE is ignored.
- Eligible core i: req[i]=1 & buf_full[i]=0.
- States:
  - IDLE: if any core eligible -> ARB next cycle.
  - ARB: pick first eligible core scanning from rr_ptr upward, wrapping modulo NCORES. Latch owner and base=req_addr[owner]. Set busy=1. -> ISSUE. If no core is eligible (a flush/req drop raced), -> IDLE.
  - ISSUE: mem_rd_en=1 each cycle, mem_addr=base+4*issue_cnt, issue_cnt 0..ROW_WORDS-1. After the last issue -> DRAIN. Address adds are 32-bit modular and wrap silently.
  - DRAIN: no issue; wait until ret_cnt==ROW_WORDS.
- Return path, active in ISSUE and DRAIN: on mem_rd_valid, register data. Next cycle: buf_wr_en[owner]=1, buf_wr_idx=ret_cnt, buf_wr_data=data. ret_cnt increments.
- Completion: the cycle after the final buffer write, buf_full[owner]<=1, busy<=0, rr_ptr<=owner+1 (mod NCORES), state -> IDLE.
- Minimum fill latency, ARB entry to buf_full: ROW_WORDS + mem latency + 2 cycles.
- flush[i] clears buf_full[i] next cycle. A flush on a core with buf_full=0 has no effect.
- Flush of the current owner during a fill is ignored: the flag is still set at completion.
- Simultaneous set and flush on the same core in the same cycle: set wins.
- Requests arriving during a fill wait; the arbiter is non-preemptive.
- req dropping mid-fill does not abort the fill.
- mem_rd_valid outside ISSUE/DRAIN is ignored. Returns beyond ROW_WORDS are ignored.

Test Plan:
- Single request: reset, req=4'b0001, req_addr0=0x100, latency 1 -> mem_addr 0x100..0x13C on 16 consecutive cycles; buf_wr_en=0001 with idx 0..15 carrying the returned data; buf_full=0001 exactly 19 cycles after ARB; busy low afterwards.
- Round-robin: req=4'b1111 held, flush pulsed after each completion -> grant order 0,1,2,3,0; no core granted twice while another eligible core waits.
- Full blocking: buf_full[2]=1, req[2]=1 and no other requests -> stays IDLE, mem_rd_en=0. Pulse flush[2] -> fill of core 2 starts 2 cycles later.
- Owner flush race: flush[owner] mid-fill, then another flush on the completion cycle -> buf_full[owner]=1 after completion (set wins).
- Async reset mid-fill: drop Rst_n at issue_cnt=7 -> all outputs zero immediately without a clock edge. Release with a stale mem_rd_valid=1 -> no buf_wr_en pulse; a fresh fill then starts from word 0.
- Latency/wrap: mem latency 3, req_addr=0xFFFFFFF0 -> addresses wrap to 0x00000000..; 16 writes, in order, idx 0..15; buf_full set after the 16th.
